alu_seq: RTL and testbench
==========================

# alu_seq

- Parametrised, handshaked successor to the team's 64-bit combinational ALU.
- Adds a registered result, valid/ready flow control, left/arithmetic shifts and an iterative unsigned multiply.
- Sits between the register-read stage and writeback of the multi-cycle CPU datapath.
- Single-cycle ops return one cycle after acceptance; multiply stalls the unit for WIDTH cycles.

## Interface
- WIDTH, 64: datapath width; power of two, ≥ 8.
- SHW, $clog2(WIDTH): shift-distance width (derived, not overridable).

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands/op present.
- in_ready  out  1  unit can accept this cycle.
- op  in  4  operation code (alu_pkg::op_e).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result/flags valid; held until taken.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- negative, zero, overflow, carry_out  out  1 each  registered flags.

## Operation
- Op codes:
  - PASS_B=0: b.
  - ADD=1: a+b.
  - SUB=2: a+~b+1.
  - AND=3, OR=4, XOR=5.
  - LSR=6: a >> b[SHW-1:0].
  - LSL=7.
  - ASR=8: sign-fill.
  - MUL=9: low WIDTH bits of the unsigned a*b.
  - 10–15 are illegal.
- Flags, all ops:
  - negative = result[WIDTH-1].
  - zero = (result == 0).
- ADD/SUB flags:
  - carry_out = carry out of the MSB; for SUB, 1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB (signed overflow).
- Logic, shift and PASS_B: carry_out=0, overflow=0.
- MUL flags: carry_out=0, overflow = 1 iff the full 2·WIDTH product has any nonzero bit above WIDTH-1.
- Illegal op: result=0, zero=1, other flags 0, latency 1.
- FSM:
  - IDLE: accept → registers result (non-MUL) or loads multiplier (MUL → BUSY).
  - BUSY: one shift-add step per cycle, 6/7-bit counter from 0 to WIDTH-1.
    - After the final step, result/flags are registered and out_valid is set.
    - Return to IDLE.
- Multiplier state:
  - 2·WIDTH accumulator.
  - Shifted multiplicand.
  - Multiplier shift register; step adds the multiplicand when the multiplier LSB is 1.

## Timing
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
- Non-MUL accepted at edge k → out_valid high after edge k+1. Full throughput: one op per cycle with out_ready held high.
- MUL accepted at edge k → out_valid high after edge k+WIDTH. in_ready=0 throughout BUSY.
- Simultaneous out-take and in-accept in one cycle is legal: the new result replaces the old at the same edge, and out_valid stays high.
- When out_valid && !out_ready:
  - result and flags are held stable.
  - in_ready=0.
  - A MUL cannot complete into an occupied output: it is only accepted when the output is free or draining.
- Input operands need only be valid on the accept cycle. The unit captures everything it needs.
- reset values: state=IDLE, counter=0, out_valid=0, result=0, all flags 0. in_ready=1 on the first cycle after reset deasserts.
- reset mid-BUSY aborts the multiply. No out_valid is produced, and the next accept starts fresh.
- The counter never wraps: exactly WIDTH steps occur per MUL, including when b=0 (no early exit).

## Structure
- Package alu_pkg:
  - op_e: 4-bit enum of the codes above.
  - state_e: IDLE, BUSY.
  - Function flags_addsub(): computes carry/overflow from the MSB carries.
- Sub-module alu_mul_iter, parametrised by WIDTH:
  - Ports: start, a, b, done, prod_lo, prod_hi_nz.
  - Owns the accumulator and counter.
  - alu_seq owns the handshake, the single-cycle datapath and the output registers.

## Test plan
- Reset then ADD, WIDTH=64:
  - a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → result 64'h8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, one cycle after accept.
  - SUB a=5, b=5 → result 0, zero=1, carry_out=1.
- Shifts, WIDTH=64, a=64'h8000_0000_0000_00F0:
  - LSR by 4 → 64'h0800_0000_0000_000F.
  - ASR by 4 → 64'hF800_0000_0000_000F.
  - LSL by 68 → shift distance is 4 → 64'h0000_0000_0000_0F00.
- MUL, WIDTH=8, a=8'd15, b=8'd17:
  - result 8'hFF, overflow=0, out_valid exactly 8 cycles after accept, in_ready=0 throughout.
  - Then a=16, b=16 → result 0, zero=1, overflow=1.
- Backpressure: hold out_ready=0 with out_valid high for 5 cycles.
  - result is stable and in_ready=0.
  - Then stream 10 ADDs with out_ready=1 → 10 results on consecutive cycles, in order.
- Assert reset on cycle 3 of a WIDTH=64 MUL:
  - out_valid never rises for it.
  - A following XOR a=8'hF0, b=8'hFF (WIDTH=8 build) returns 8'h0F one cycle after accept.
- Illegal op 4'hC → result 0, zero=1, negative/overflow/carry_out 0, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and flag helpers for the sequential ALU.
// Imported by alu_seq and its iterative multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    PASS_B = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    AND    = 4'd3,
    OR     = 4'd4,
    XOR    = 4'd5,
    LSR    = 4'd6,
    LSL    = 4'd7,
    ASR    = 4'd8,
    MUL    = 4'd9
  } op_e;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  // Returns {carry, overflow}; carry into MSB is recovered from the sum bit
  function automatic logic [1:0] flags_addsub(
    input logic aMsb,
    input logic bMsb,
    input logic sMsb,
    input logic cOut
  );
    logic cIn;
    cIn = aMsb ^ bMsb ^ sMsb;
    return {cOut, cIn ^ cOut};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// The first step happens on the start edge; done flags the last step.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic               busy;

  assign accNext    = mplier[0] ? acc + mcand : acc;
  assign done       = busy && (cnt == SHW'(WIDTH - 1));
  assign prod_lo    = accNext[WIDTH-1:0];
  assign prod_hi_nz = |accNext[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= SHW'(1);
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{WIDTH{1'b0}}, a} << 1;
      mplier <= b >> 1;
    end else if (busy) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + SHW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and flags.
// Single-cycle ops return next cycle; MUL holds the unit for WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  logic             accept;
  logic             isSub;
  logic             mulStart;
  logic             mulDone;
  logic             mulHiNz;
  logic [WIDTH-1:0] mulLo;
  logic [WIDTH-1:0] bOp;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluV;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mulStart = accept && (op == MUL);
  assign isSub    = (op == SUB);
  assign bOp      = isSub ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, bOp} + (WIDTH+1)'(isSub);
  assign shamt    = b[SHW-1:0];

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (op)
      PASS_B: aluRes = b;
      ADD, SUB: begin
        aluRes       = sum[WIDTH-1:0];
        {aluC, aluV} = flags_addsub(a[WIDTH-1], bOp[WIDTH-1],
                                    sum[WIDTH-1], sum[WIDTH]);
      end
      AND:     aluRes = a & b;
      OR:      aluRes = a | b;
      XOR:     aluRes = a ^ b;
      LSR:     aluRes = a >> shamt;
      LSL:     aluRes = a << shamt;
      ASR:     aluRes = $unsigned($signed(a) >>> shamt);
      default: aluRes = '0;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) uMul (
    .clk        (clk),
    .reset      (reset),
    .start      (mulStart),
    .a          (a),
    .b          (b),
    .done       (mulDone),
    .prod_lo    (mulLo),
    .prod_hi_nz (mulHiNz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && op == MUL) begin
            state <= BUSY;
          end else if (accept) begin
            result    <= aluRes;
            negative  <= aluRes[WIDTH-1];
            zero      <= (aluRes == '0);
            overflow  <= aluV;
            carry_out <= aluC;
            out_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (mulDone) begin
            result    <= mulLo;
            negative  <= mulLo[WIDTH-1];
            zero      <= (mulLo == '0);
            overflow  <= mulHiNz;
            carry_out <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 64-bit and 8-bit instances side by side.
// Vector table for single-cycle ops, hand sequences for MUL/backpressure/reset.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        iv64, ir64, ov64, or64;
  logic [3:0]  op64;
  logic [63:0] a64, b64, res64;
  logic        n64, z64, v64, c64;

  logic        iv8, ir8, ov8, or8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic        n8, z8, v8, c8;

  int nChk  = 0;
  int nFail = 0;

  vec_t vecs[13];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(iv64), .in_ready(ir64),
    .op(op64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(or64),
    .result(res64), .negative(n64), .zero(z64),
    .overflow(v64), .carry_out(c64)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8),
    .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8),
    .result(res8), .negative(n8), .zero(z8),
    .overflow(v8), .carry_out(c8)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run64(input vec_t v, input string nm);
    @(negedge clk);
    op64 = v.op; a64 = v.a; b64 = v.b;
    iv64 = 1'b1; or64 = 1'b1;
    chk({nm, ".in_ready"}, 64'(ir64), 64'd1);
    @(posedge clk);
    #1 iv64 = 1'b0;
    @(negedge clk);
    chk({nm, ".out_valid"}, 64'(ov64), 64'd1);
    chk({nm, ".result"}, res64, v.res);
    chk({nm, ".negative"}, 64'(n64), 64'(v.n));
    chk({nm, ".zero"}, 64'(z64), 64'(v.z));
    chk({nm, ".overflow"}, 64'(v64), 64'(v.v));
    chk({nm, ".carry_out"}, 64'(c64), 64'(v.c));
  endtask

  task automatic mul8(input logic [7:0] ma, input logic [7:0] mb,
                      input logic [7:0] er, input logic ez,
                      input logic ev, input string nm);
    int badWait;
    badWait = 0;
    @(negedge clk);
    op8 = MUL; a8 = ma; b8 = mb;
    iv8 = 1'b1; or8 = 1'b1;
    chk({nm, ".in_ready"}, 64'(ir8), 64'd1);
    @(posedge clk);
    #1 iv8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (ov8 !== 1'b0 || ir8 !== 1'b0) badWait++;
    end
    chk({nm, ".busy_cycles_bad"}, 64'(badWait), 64'd0);
    @(negedge clk);
    chk({nm, ".out_valid_at8"}, 64'(ov8), 64'd1);
    chk({nm, ".result"}, 64'(res8), 64'(er));
    chk({nm, ".zero"}, 64'(z8), 64'(ez));
    chk({nm, ".overflow"}, 64'(v8), 64'(ev));
    chk({nm, ".carry_out"}, 64'(c8), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1;
    iv64 = 1'b0; or64 = 1'b1; op64 = '0; a64 = '0; b64 = '0;
    iv8  = 1'b0; or8  = 1'b1; op8  = '0; a8  = '0; b8  = '0;

    vecs[0]  = '{ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                 64'h8000_0000_0000_0000, 1, 0, 1, 0};
    vecs[1]  = '{SUB, 64'd5, 64'd5, 64'd0, 0, 1, 0, 1};
    vecs[2]  = '{LSR, 64'h8000_0000_0000_00F0, 64'd4,
                 64'h0800_0000_0000_000F, 0, 0, 0, 0};
    vecs[3]  = '{ASR, 64'h8000_0000_0000_00F0, 64'd4,
                 64'hF800_0000_0000_000F, 1, 0, 0, 0};
    vecs[4]  = '{LSL, 64'h8000_0000_0000_00F0, 64'd68,
                 64'h0000_0000_0000_0F00, 0, 0, 0, 0};
    vecs[5]  = '{4'hC, 64'd123, 64'd456, 64'd0, 0, 1, 0, 0};
    vecs[6]  = '{PASS_B, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0};
    vecs[7]  = '{AND, 64'hF0F0, 64'hFF00, 64'hF000, 0, 0, 0, 0};
    vecs[8]  = '{OR, 64'hF0F0, 64'h0F0F, 64'hFFFF, 0, 0, 0, 0};
    vecs[9]  = '{XOR, 64'h5555_5555_5555_5555,
                 64'hAAAA_AAAA_AAAA_AAAA,
                 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0};
    vecs[10] = '{ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                 64'd0, 0, 1, 0, 1};
    vecs[11] = '{SUB, 64'd0, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0};
    vecs[12] = '{SUB, 64'h8000_0000_0000_0000, 64'd1,
                 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 64'(ir64), 64'd1);
    chk("rst.out_valid", 64'(ov64), 64'd0);
    chk("rst.result", res64, 64'd0);
    chk("rst.flags", 64'({n64, z64, v64, c64}), 64'd0);

    for (int i = 0; i < 13; i++)
      run64(vecs[i], $sformatf("vec%0d", i));

    mul8(8'd15, 8'd17, 8'hFF, 1'b0, 1'b0, "mul15x17");
    mul8(8'd16, 8'd16, 8'h00, 1'b1, 1'b1, "mul16x16");

    // full-width multiply latency
    @(negedge clk);
    op64 = MUL; a64 = 64'd3; b64 = 64'hFFFF_FFFF_FFFF_FFFF;
    iv64 = 1'b1; or64 = 1'b1;
    @(posedge clk);
    #1 iv64 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ov64 === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("mul64.latency", 64'(lat), 64'd64);
    chk("mul64.result", res64, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul64.overflow", 64'(v64), 64'd1);

    // backpressure then streaming
    @(negedge clk);
    op64 = ADD; a64 = 64'd3; b64 = 64'd4;
    iv64 = 1'b1; or64 = 1'b0;
    @(posedge clk);
    #1 a64 = 64'd0; b64 = 64'd1000;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ov64 !== 1'b1 || res64 !== 64'd7 || ir64 !== 1'b0)
        seen++;
    end
    chk("stall.held_bad_cycles", 64'(seen), 64'd0);
    or64 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k < 9) a64 = 64'((k + 1) * 3);
      else iv64 = 1'b0;
      @(negedge clk);
      chk($sformatf("stream%0d.valid", k), 64'(ov64), 64'd1);
      chk($sformatf("stream%0d.result", k), res64,
          64'(k * 3 + 1000));
    end

    // reset during a multiply
    @(negedge clk);
    op64 = MUL; a64 = 64'd3; b64 = 64'd5;
    iv64 = 1'b1; or64 = 1'b1;
    @(posedge clk);
    #1 iv64 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ov64 === 1'b1) seen++;
    end
    chk("rstmul.out_valid_seen", 64'(seen), 64'd0);
    chk("rstmul.in_ready", 64'(ir64), 64'd1);

    @(negedge clk);
    op8 = XOR; a8 = 8'hF0; b8 = 8'hFF;
    iv8 = 1'b1; or8 = 1'b1;
    chk("xor8.in_ready", 64'(ir8), 64'd1);
    @(posedge clk);
    #1 iv8 = 1'b0;
    @(negedge clk);
    chk("xor8.out_valid", 64'(ov8), 64'd1);
    chk("xor8.result", 64'(res8), 64'h0F);
    chk("xor8.flags", 64'({n8, z8, v8, c8}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
